// File: rtl/d5m_src_pkg.sv
// Shared types and constants for the D5M pixel source: FSM states, pattern codes
// and fixed pixel levels.
package d5m_src_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FRONT,
    LINE,
    HBLANK,
    BACK,
    VBLANK
  } src_state_t;

  localparam logic [1:0] PAT_FLAT   = 2'd0;
  localparam logic [1:0] PAT_RAMP   = 2'd1;
  localparam logic [1:0] PAT_BARS   = 2'd2;
  localparam logic [1:0] PAT_SQUARE = 2'd3;

  localparam logic [11:0] FLAT_LVL   = 12'h200;
  localparam logic [11:0] BRIGHT_LVL = 12'hFFF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/d5m_pixel_source_if.sv
// D5M parallel pixel bus: 12-bit data with frame and line valid.
interface d5m_pixel_source_if;
  logic [11:0] d5m_d;
  logic        d5m_fval;
  logic        d5m_lval;

  modport master (output d5m_d, d5m_fval, d5m_lval);
  modport slave  (input  d5m_d, d5m_fval, d5m_lval);
endinterface

// File: rtl/d5m_pattern_gen.sv
// Combinational test-pattern pixel for position (x, y) under the frame-latched
// pattern controls.
module d5m_pattern_gen
  import d5m_src_pkg::*;
#(
  parameter int          ACTIVE_W = 1280,
  parameter logic [11:0] DARK_LVL = 12'h040
) (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [1:0]  pat,
  input  logic [10:0] obj_x,
  input  logic [9:0]  obj_y,
  input  logic [9:0]  obj_size,
  output logic [11:0] pix
);

  localparam int BAND_W = (ACTIVE_W / 8 < 1) ? 1 : ACTIVE_W / 8;

  logic [11:0] band;
  logic [11:0] band_mask;
  logic [11:0] x_end;
  logic [11:0] y_end;
  logic        in_square;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    band = x / 12'(BAND_W);
    // Bayer cell: row 0 = G R, row 1 = B G; R follows band bit 2, G bit 1, B bit 0.
    if (!y[0] && x[0])     band_mask = 12'd4;
    else if (y[0] == x[0]) band_mask = 12'd2;
    else                   band_mask = 12'd1;

    // 12-bit sums cannot wrap, so a square running off the frame is simply clipped.
    x_end     = {1'b0, obj_x} + {2'b00, obj_size};
    y_end     = {2'b00, obj_y} + {2'b00, obj_size};
    in_square = (x >= {1'b0, obj_x}) && (x < x_end) &&
                (y >= {2'b00, obj_y}) && (y < y_end);

    case (pat)
      PAT_FLAT:   pix = FLAT_LVL;
      PAT_RAMP:   pix = x;
      PAT_BARS:   pix = (|(band & band_mask)) ? BRIGHT_LVL : 12'h000;
      default:    pix = in_square ? BRIGHT_LVL : DARK_LVL;
    endcase
  end

endmodule

// File: rtl/d5m_pixel_source.sv
// D5M sensor emulator: generates CCD_Capture-compatible FVAL/LVAL timing and a
// selectable Bayer test pattern, with all outputs registered.
module d5m_pixel_source
  import d5m_src_pkg::*;
#(
  parameter int          ACTIVE_W = 1280,
  parameter int          ACTIVE_H = 960,
  parameter int          FRONT_P  = 16,
  parameter int          H_BLANK  = 64,
  parameter int          BACK_P   = 16,
  parameter int          V_BLANK  = 256,
  parameter logic [11:0] DARK_LVL = 12'h040
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [1:0]                pattern_sel,
  input  logic [10:0]               obj_x,
  input  logic [9:0]                obj_y,
  input  logic [9:0]                obj_size,
  d5m_pixel_source_if.master        d5m,
  output logic [15:0]               frame_count,
  output logic                      frame_done
);

  localparam int MAX_FB    = (FRONT_P > BACK_P) ? FRONT_P : BACK_P;
  localparam int MAX_HV    = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BLANK_MAX = (MAX_FB > MAX_HV) ? MAX_FB : MAX_HV;
  localparam int XW        = cnt_w(ACTIVE_W);
  localparam int YW        = cnt_w(ACTIVE_H);
  localparam int CW        = cnt_w(BLANK_MAX);

  src_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  logic [1:0]  pat_q;
  logic [10:0] obj_x_q;
  logic [9:0]  obj_y_q;
  logic [9:0]  obj_size_q;

  logic [11:0] pix;
  logic [11:0] d_d;
  logic        fval_d, lval_d, done_d;
  logic        frame_start;

  assign frame_start = (state_d == FRONT) && (state_q != FRONT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pat_q      <= '0;
      obj_x_q    <= '0;
      obj_y_q    <= '0;
      obj_size_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
      x_q     <= (state_q == LINE && state_d == LINE) ? x_q + XW'(1) : '0;
      if (frame_start) begin
        y_q        <= '0;
        pat_q      <= pattern_sel;
        obj_x_q    <= obj_x;
        obj_y_q    <= obj_y;
        obj_size_q <= obj_size;
      end else if (state_q == HBLANK && state_d == LINE) begin
        y_q <= y_q + YW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (enable) state_d = FRONT;
      FRONT:  if (cnt_q == CW'(FRONT_P - 1)) state_d = LINE;
      LINE:   if (x_q == XW'(ACTIVE_W - 1))
                state_d = (y_q == YW'(ACTIVE_H - 1)) ? BACK : HBLANK;
      HBLANK: if (cnt_q == CW'(H_BLANK - 1)) state_d = LINE;
      BACK:   if (cnt_q == CW'(BACK_P - 1)) state_d = VBLANK;
      VBLANK: if (cnt_q == CW'(V_BLANK - 1)) state_d = enable ? FRONT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  d5m_pattern_gen #(
    .ACTIVE_W (ACTIVE_W),
    .DARK_LVL (DARK_LVL)
  ) u_pattern_gen (
    .x        (12'(x_q)),
    .y        (12'(y_q)),
    .pat      (pat_q),
    .obj_x    (obj_x_q),
    .obj_y    (obj_y_q),
    .obj_size (obj_size_q),
    .pix      (pix)
  );

  always_comb begin
    fval_d = (state_q == FRONT) || (state_q == LINE) ||
             (state_q == HBLANK) || (state_q == BACK);
    lval_d = (state_q == LINE);
    d_d    = lval_d ? pix : 12'h000;
    done_d = (state_q == VBLANK) && (cnt_q == '0);
  end

  // Output stage: one cycle behind the FSM, so every output comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d5m.d5m_d    <= '0;
      d5m.d5m_fval <= 1'b0;
      d5m.d5m_lval <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
    end else begin
      d5m.d5m_d    <= d_d;
      d5m.d5m_fval <= fval_d;
      d5m.d5m_lval <= lval_d;
      frame_done   <= done_d;
      if (done_d) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_d5m_pixel_source.sv
// Scoreboard bench for d5m_pixel_source: a frame-level model queues the expected
// per-cycle bus state and a monitor compares once each frame starts.
module tb_d5m_pixel_source;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int FP   = 2;
  localparam int HB   = 3;
  localparam int BP   = 2;
  localparam int VB   = 5;
  localparam int FLEN = FP + W * H + (H - 1) * HB + BP + VB;
  localparam int IDLE_N = 8;

  typedef struct {
    logic        fval;
    logic        lval;
    logic [11:0] d;
    logic        done;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [10:0] obj_x = '0;
  logic [9:0]  obj_y = '0;
  logic [9:0]  obj_size = '0;
  logic [15:0] frame_count;
  logic        frame_done;

  d5m_pixel_source_if d5m ();

  d5m_pixel_source #(
    .ACTIVE_W (W), .ACTIVE_H (H), .FRONT_P (FP),
    .H_BLANK (HB), .BACK_P (BP), .V_BLANK (VB), .DARK_LVL (12'h040)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .obj_size    (obj_size),
    .d5m         (d5m.master),
    .frame_count (frame_count),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  bit          armed = 0;
  bit          mon_en = 0;
  logic [15:0] exp_fc = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic fv, input logic lv, input logic [11:0] d,
                              input logic dn, input logic [15:0] fc);
    exp_t e;
    e.fval = fv; e.lval = lv; e.d = d; e.done = dn; e.fc = fc;
    return e;
  endfunction

  // Reference pixel straight from the pattern definitions.
  function automatic logic [11:0] ref_pix(input int pat, input int x, input int y,
                                          input int ox, input int oy, input int sz);
    int band, bw;
    bit on;
    case (pat)
      0: return 12'h200;
      1: return 12'(x);
      2: begin
        bw   = (W / 8 < 1) ? 1 : W / 8;
        band = x / bw;
        if (y % 2 == 0 && x % 2 == 1) on = ((band >> 2) & 1) == 1;
        else if (y % 2 == x % 2)      on = ((band >> 1) & 1) == 1;
        else                          on = (band & 1) == 1;
        return on ? 12'hFFF : 12'h000;
      end
      default:
        return (x >= ox && x < ox + sz && y >= oy && y < oy + sz) ? 12'hFFF : 12'h040;
    endcase
  endfunction

  task automatic push_frame(input int pat, input int ox, input int oy, input int sz,
                            input int idle_n);
    for (int i = 0; i < FP; i++) exp_q.push_back(mk(1, 0, 0, 0, exp_fc));
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++)
        exp_q.push_back(mk(1, 1, ref_pix(pat, x, y, ox, oy, sz), 0, exp_fc));
      if (y < H - 1)
        for (int i = 0; i < HB; i++) exp_q.push_back(mk(1, 0, 0, 0, exp_fc));
    end
    for (int i = 0; i < BP; i++) exp_q.push_back(mk(1, 0, 0, 0, exp_fc));
    exp_fc = exp_fc + 16'd1;
    for (int i = 0; i < VB; i++) exp_q.push_back(mk(0, 0, 0, i == 0, exp_fc));
    for (int i = 0; i < idle_n; i++) exp_q.push_back(mk(0, 0, 0, 0, exp_fc));
  endtask

  // Monitor: locks onto the first FVAL-high cycle while expectations are pending.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!armed && exp_q.size() != 0 && d5m.d5m_fval) armed = 1;
      if (armed) begin
        e = exp_q.pop_front();
        vectors++;
        if (d5m.d5m_fval !== e.fval || d5m.d5m_lval !== e.lval || d5m.d5m_d !== e.d ||
            frame_done !== e.done || frame_count !== e.fc) begin
          miscompares++;
          $display("FAIL bus_cycle @%0t: got fval=%b lval=%b d=%h done=%b fc=%h, expected fval=%b lval=%b d=%h done=%b fc=%h",
                   $time, d5m.d5m_fval, d5m.d5m_lval, d5m.d5m_d, frame_done, frame_count,
                   e.fval, e.lval, e.d, e.done, e.fc);
        end
        if (exp_q.size() == 0) armed = 0;
      end else if (d5m.d5m_fval || d5m.d5m_lval || frame_done) begin
        miscompares++;
        $display("FAIL unexpected_frame @%0t: got fval=%b lval=%b done=%b, expected all 0",
                 $time, d5m.d5m_fval, d5m.d5m_lval, frame_done);
      end
    end
  end

  task automatic wait_below(input int n, input int budget);
    int c = 0;
    while (exp_q.size() >= n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() >= n) begin
      miscompares++;
      $display("FAIL frame_start_timeout: got %0d pending, expected below %0d", exp_q.size(), n);
    end
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
      armed = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pats[10], oxs[10], oys[10], szs[10];
    int c;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_d", 32'(d5m.d5m_d), 32'h0);
    check("reset_fval", 32'(d5m.d5m_fval), 32'h0);
    check("reset_lval", 32'(d5m.d5m_lval), 32'h0);
    check("reset_count", 32'(frame_count), 32'h0);
    check("reset_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    mon_en = 1;
    repeat (5) @(negedge clk);
    check("idle_fval", 32'(d5m.d5m_fval), 32'h0);

    // Directed frames followed by random ones, back to back
    pats[0] = 1; oxs[0] = 0; oys[0] = 0; szs[0] = 0;
    pats[1] = 3; oxs[1] = 6; oys[1] = 2; szs[1] = 4;
    pats[2] = 0; oxs[2] = 0; oys[2] = 0; szs[2] = 0;
    pats[3] = 2; oxs[3] = 0; oys[3] = 0; szs[3] = 0;
    pats[4] = 3; oxs[4] = 1; oys[4] = 1; szs[4] = 0;
    for (int k = 5; k < 10; k++) begin
      pats[k] = int'($urandom_range(3, 0));
      oxs[k]  = int'($urandom_range(12, 0));
      oys[k]  = int'($urandom_range(5, 0));
      szs[k]  = int'($urandom_range(6, 0));
    end
    for (int k = 0; k < 10; k++) begin
      pattern_sel = 2'(pats[k]);
      obj_x = 11'(oxs[k]); obj_y = 10'(oys[k]); obj_size = 10'(szs[k]);
      push_frame(pats[k], oxs[k], oys[k], szs[k], (k == 9) ? IDLE_N : 0);
      enable = 1'b1;
      wait_below(FLEN + ((k == 9) ? IDLE_N : 0), 3 * FLEN);
      if (k == 9) enable = 1'b0;
    end
    wait_drain(3 * FLEN);

    // Controls changed during line 1 must not affect the running frame
    pattern_sel = 2'd1; obj_x = 0; obj_y = 0; obj_size = 0;
    push_frame(1, 0, 0, 0, IDLE_N);
    enable = 1'b1;
    wait_below(FLEN + IDLE_N - 14, 3 * FLEN);
    pattern_sel = 2'd3; obj_x = 11'd2; obj_y = 10'd1; obj_size = 10'd3;
    enable = 1'b0;
    wait_drain(3 * FLEN);
    repeat (10) @(negedge clk);
    check("idle_after_disable", 32'(d5m.d5m_fval), 32'h0);

    // Asynchronous reset in the middle of a line
    mon_en = 0;
    pattern_sel = 2'd1;
    enable = 1'b1;
    c = 0;
    while (!d5m.d5m_lval && c < 4 * FLEN) begin
      @(negedge clk);
      c++;
    end
    check("reached_line", 32'(d5m.d5m_lval), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("midline_reset_d", 32'(d5m.d5m_d), 32'h0);
    check("midline_reset_fval", 32'(d5m.d5m_fval), 32'h0);
    check("midline_reset_lval", 32'(d5m.d5m_lval), 32'h0);
    check("midline_reset_count", 32'(frame_count), 32'h0);
    exp_q.delete();
    armed = 0;
    exp_fc = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_idle", 32'({d5m.d5m_fval, d5m.d5m_lval, frame_done}), 32'h0);
    end
    mon_en = 1;

    // frame_count wrap from 16'hFFFF
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    exp_fc = 16'hFFFF;
    pattern_sel = 2'd2;
    push_frame(2, 0, 0, 0, IDLE_N);
    enable = 1'b1;
    wait_below(FLEN + IDLE_N, 3 * FLEN);
    enable = 1'b0;
    wait_drain(3 * FLEN);
    check("wrapped_count", 32'(frame_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
